adpll_network_sequencer: RTL and testbench
==========================================

# adpll_network_sequencer

Controller that brings up the 2x2 ADPLL network in a defined order and configures it at runtime. It drives the per-node enables, the neighbour weight sets (uni-/bi-directional) and the shared Kp/Ki gains. It gates each bring-up stage on phase-error lock of the active nodes, times out into a fault state, and ramps gains from acquisition values to tracking values. It sits beside the four NetworkADPLL instances in the fpga_clk_i domain, replacing the switch-driven enable, weight and gain wiring.

## Interface
- PDET_WIDTH, 8: width of each signed phase-error input.
- LOCK_THRESH, 4: max |error| counted as in-lock.
- LOCK_CYCLES, 1024: consecutive in-lock cycles needed to qualify a stage.
- LOSS_CYCLES, 64: consecutive out-of-lock cycles in S_LOCKED that declare loss.
- TIMEOUT_CYCLES, 1048576: max cycles per qualifying stage before fault.
- GAIN_STEP_CYCLES, 256: cycles between gain steps in S_RAMP.
- CNT_WIDTH, 21: width of the shared timeout/step counter; must hold TIMEOUT_CYCLES.

Ports (unit is the clock cycle):
- fpga_clk_i  in  1  single clock (258 MHz domain).
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse; starts bring-up from S_IDLE.
- clear_i  in  1  one-cycle pulse; returns to S_IDLE from any state.
- uni_dir_i  in  1  final weight mode, 1 uni-dir, 0 bi-dir; sampled on start_i.
- kp_acq_i, ki_acq_i  in  4 each  acquisition gains.
- kp_fin_i, ki_fin_i  in  4 each  tracking gains; sampled on entry to S_RAMP.
- err_11_i, err_12_i, err_21_i, err_22_i  in  PDET_WIDTH each  signed error_left outputs of each node.
- enable_o  out  4  node enables, bit0=11, bit1=12, bit2=21, bit3=22.
- weights_11_o, weights_12_o, weights_21_o, weights_22_o  out  16 each  {left,above,right,below}, 4 bits per field.
- kp_o, ki_o  out  4 each  gains to all nodes; the integration zero-pads them.
- locked_o  out  1  high only in S_LOCKED.
- fault_o  out  1  high only in S_FAULT.
- lock_lost_o  out  1  sticky; cleared by clear_i or reset.
- state_o  out  3  current state encoding.

## Operation
- States and encodings:
  - S_IDLE=0, S_ROOT=1, S_EDGE=2, S_ALL=3, S_MODE=4, S_RAMP=5, S_LOCKED=6, S_FAULT=7.
- Enables by state:
  - IDLE/FAULT 0000.
  - ROOT 0001.
  - EDGE 0111.
  - ALL, MODE, RAMP, LOCKED 1111.
- Weight tables:
  - Uni: 11={4,0,0,0}, 12={4,0,0,0}, 21={0,4,0,0}, 22={2,2,0,0}.
  - Bi: 11={2,0,1,1}, 12={2,0,0,2}, 21={0,2,2,0}, 22={2,2,0,0}.
  - IDLE through ALL use the uni table.
  - From MODE entry onward, use the table chosen by the sampled uni_dir_i.
- Magnitude:
  - |e| is computed as a two's-complement absolute value.
  - The most negative code saturates to 2^(PDET_WIDTH-1)-1.
  - A node is in-lock when |e| <= LOCK_THRESH.
- Qualifying stages and watched nodes:
  - ROOT watches {11}.
  - EDGE watches {11,12,21}.
  - ALL and MODE watch all four.
- Lock counter in qualifying stages:
  - Increments when all watched nodes are in-lock.
  - Clears to 0 on any watched node out-of-lock.
  - Reaching LOCK_CYCLES advances the state: ROOT->EDGE->ALL->MODE->RAMP.
- Timeout counter: counts every cycle in a stage; reaching TIMEOUT_CYCLES enters S_FAULT.
- Both counters clear on every state transition.
- Gains:
  - In IDLE, kp_o=ki_o=0.
  - On start_i, load the acquisition gains.
- S_RAMP:
  - Every GAIN_STEP_CYCLES, kp_o and ki_o each move independently by 1 toward their final value.
  - Exit to S_LOCKED in the cycle after both are equal to their final values.
  - No lock qualification or timeout applies in S_RAMP.
- S_LOCKED:
  - Any node out-of-lock for LOSS_CYCLES consecutive cycles sets lock_lost_o.
  - It also reloads the acquisition gains and returns to S_ALL, keeping the current weight mode.
- S_FAULT: holds until clear_i.
- Priority: reset_i > clear_i > timeout > qualification > start_i.
- start_i outside S_IDLE is ignored.

## Timing
- All outputs are registered and change on the clock edge that commits the state change.
- Reset values:
  - state_o=0, enable_o=0, weights = uni table, kp_o=ki_o=0.
  - locked_o=0, fault_o=0, lock_lost_o=0.
- start_i sampled high in cycle N: state_o=1, enable_o=0001 and acquisition gains are visible in N+1.
- Stage qualification:
  - The counter reaches LOCK_CYCLES on the LOCK_CYCLES-th consecutive in-lock cycle.
  - The next state is visible on the following edge.
- The weight change occurs in the same cycle that state_o becomes 4.
- A gain step occurs on the edge where the step counter wraps GAIN_STEP_CYCLES-1 -> 0.
  - The first step comes GAIN_STEP_CYCLES cycles after RAMP entry.
  - If the gains are already equal at RAMP entry, the state is LOCKED on the next edge.
- clear_i: state 0, enables 0 and gains 0 on the next edge.
- Asserting reset_i mid-operation forces the reset values immediately, without waiting for a clock edge.

## Test plan
Bench parameters: LOCK_CYCLES=8, TIMEOUT_CYCLES=64, GAIN_STEP_CYCLES=4, LOSS_CYCLES=4.
- Nominal bring-up: all errors 0, start_i, uni_dir_i=0, acq 8/8, fin 2/5 -> states 1,2,3,4,5,6. Each qualifying stage lasts 9 cycles, bi weights from state 4, kp 8->2 in 6 steps, ki 8->5 in 3 steps, locked_o=1.
- Glitch restart: err_11_i=5 for one cycle at count 6 in ROOT -> counter clears, ROOT lasts 8 further in-lock cycles.
- Timeout: err_12_i=-128 permanently -> saturated |e|=127, fault_o=1 and enable_o=0000 exactly 64 cycles after EDGE entry; clear_i -> state 0.
- Lock loss: in LOCKED, err_22_i=20 for 4 cycles -> lock_lost_o=1, state 3, kp_o/ki_o = acquisition gains; a 3-cycle burst causes no change.
- Priority: start_i and clear_i together in IDLE -> stays IDLE. Mid-RAMP async reset_i pulse -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/adpll_network_sequencer_if.sv
// Control/status bundle between the ADPLL network sequencer and its environment.
// The master drives the start/clear/config/error inputs; the sequencer (slave) drives the rest.
interface adpll_network_sequencer_if #(
  parameter int PDET_WIDTH = 8
);
  logic                  start_i;
  logic                  clear_i;
  logic                  uni_dir_i;
  logic [3:0]            kp_acq_i;
  logic [3:0]            ki_acq_i;
  logic [3:0]            kp_fin_i;
  logic [3:0]            ki_fin_i;
  logic [PDET_WIDTH-1:0] err_11_i;
  logic [PDET_WIDTH-1:0] err_12_i;
  logic [PDET_WIDTH-1:0] err_21_i;
  logic [PDET_WIDTH-1:0] err_22_i;
  logic [3:0]            enable_o;
  logic [15:0]           weights_11_o;
  logic [15:0]           weights_12_o;
  logic [15:0]           weights_21_o;
  logic [15:0]           weights_22_o;
  logic [3:0]            kp_o;
  logic [3:0]            ki_o;
  logic                  locked_o;
  logic                  fault_o;
  logic                  lock_lost_o;
  logic [2:0]            state_o;

  modport master (
    output start_i, clear_i, uni_dir_i, kp_acq_i, ki_acq_i, kp_fin_i, ki_fin_i,
           err_11_i, err_12_i, err_21_i, err_22_i,
    input  enable_o, weights_11_o, weights_12_o, weights_21_o, weights_22_o,
           kp_o, ki_o, locked_o, fault_o, lock_lost_o, state_o
  );

  modport slave (
    input  start_i, clear_i, uni_dir_i, kp_acq_i, ki_acq_i, kp_fin_i, ki_fin_i,
           err_11_i, err_12_i, err_21_i, err_22_i,
    output enable_o, weights_11_o, weights_12_o, weights_21_o, weights_22_o,
           kp_o, ki_o, locked_o, fault_o, lock_lost_o, state_o
  );
endinterface

// File: rtl/adpll_network_sequencer.sv
// Bring-up/runtime sequencer for the 2x2 ADPLL network: staged enables gated on lock,
// weight-mode switch, acquisition->tracking gain ramp, lock-loss recovery and timeout fault.

// Per-node lock detector: saturating |e| compared against the lock threshold.
module adpll_lock_det #(
  parameter int W      = 8,
  parameter int THRESH = 4
) (
  input  logic signed [W-1:0] err,
  output logic                in_lock
);
  localparam logic [W-1:0] THR = W'(THRESH);
  logic [W-1:0] mag;

  always_comb begin
    if (!err[W-1])                          mag = err;
    else if (err == {1'b1, {(W-1){1'b0}}})  mag = {1'b0, {(W-1){1'b1}}};
    else                                    mag = -err;
  end

  assign in_lock = (mag <= THR);
endmodule

module adpll_network_sequencer #(
  parameter int PDET_WIDTH       = 8,
  parameter int LOCK_THRESH      = 4,
  parameter int LOCK_CYCLES      = 1024,
  parameter int LOSS_CYCLES      = 64,
  parameter int TIMEOUT_CYCLES   = 1048576,
  parameter int GAIN_STEP_CYCLES = 256,
  parameter int CNT_WIDTH        = 21
) (
  input  logic                         fpga_clk_i,
  input  logic                         reset_i,
  adpll_network_sequencer_if.slave     bus
);
  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam int LSW = $clog2(LOSS_CYCLES + 1);

  // Index 0 = node 11 ... index 3 = node 22; fields {left,above,right,below}.
  localparam logic [3:0][15:0] UNI_W = {16'h2200, 16'h0400, 16'h4000, 16'h4000};
  localparam logic [3:0][15:0] BI_W  = {16'h2200, 16'h0220, 16'h2002, 16'h2011};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ROOT = 3'd1, S_EDGE = 3'd2, S_ALL = 3'd3,
    S_MODE = 3'd4, S_RAMP = 3'd5, S_LOCKED = 3'd6, S_FAULT = 3'd7
  } state_t;

  state_t                state, state_nxt;
  logic [LCW-1:0]        lock_cnt;
  logic [LSW-1:0]        loss_cnt;
  logic [CNT_WIDTH-1:0]  tmo_cnt;
  logic [3:0]            kp_r, ki_r, kp_fin_r, ki_fin_r;
  logic                  uni_sel, bi_active, lock_lost_r, locked_r, fault_r;
  logic [3:0]            enable_r;
  logic [3:0][15:0]      weights_r;

  logic [3:0][PDET_WIDTH-1:0] err_v;
  logic [3:0]            in_lock, watch;
  logic                  all_ok, any_oor, qual, tmo_hit, loss_hit, step, gains_eq;
  logic                  bi_active_nxt;

  assign err_v = {bus.err_22_i, bus.err_21_i, bus.err_12_i, bus.err_11_i};

  for (genvar n = 0; n < 4; n++) begin : g_node
    adpll_lock_det #(.W(PDET_WIDTH), .THRESH(LOCK_THRESH)) u_det (
      .err     (err_v[n]),
      .in_lock (in_lock[n])
    );
  end

  function automatic logic [3:0] en_of(state_t s);
    case (s)
      S_ROOT:                          en_of = 4'b0001;
      S_EDGE:                          en_of = 4'b0111;
      S_ALL, S_MODE, S_RAMP, S_LOCKED: en_of = 4'b1111;
      default:                         en_of = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] toward(logic [3:0] cur, logic [3:0] fin);
    if (cur < fin)      toward = cur + 4'd1;
    else if (cur > fin) toward = cur - 4'd1;
    else                toward = cur;
  endfunction

  always_comb begin
    watch = 4'b0000;
    case (state)
      S_ROOT:        watch = 4'b0001;
      S_EDGE:        watch = 4'b0111;
      S_ALL, S_MODE: watch = 4'b1111;
      default:       watch = 4'b0000;
    endcase
  end

  assign all_ok   = &(in_lock | ~watch);
  assign any_oor  = ~&in_lock;
  assign qual     = (lock_cnt == LCW'(LOCK_CYCLES));
  assign tmo_hit  = (tmo_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign loss_hit = any_oor && (loss_cnt == LSW'(LOSS_CYCLES - 1));
  assign step     = (state == S_RAMP) && (tmo_cnt == CNT_WIDTH'(GAIN_STEP_CYCLES - 1));
  assign gains_eq = (kp_r == kp_fin_r) && (ki_r == ki_fin_r);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (bus.start_i) state_nxt = S_ROOT;
      S_ROOT:   if (tmo_hit) state_nxt = S_FAULT; else if (qual) state_nxt = S_EDGE;
      S_EDGE:   if (tmo_hit) state_nxt = S_FAULT; else if (qual) state_nxt = S_ALL;
      S_ALL:    if (tmo_hit) state_nxt = S_FAULT; else if (qual) state_nxt = S_MODE;
      S_MODE:   if (tmo_hit) state_nxt = S_FAULT; else if (qual) state_nxt = S_RAMP;
      S_RAMP:   if (gains_eq) state_nxt = S_LOCKED;
      S_LOCKED: if (loss_hit) state_nxt = S_ALL;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
    if (bus.clear_i) state_nxt = S_IDLE;
  end

  // Once MODE has been entered, the chosen weight table sticks until IDLE.
  assign bi_active_nxt = (state_nxt != S_IDLE) && (bi_active || state_nxt == S_MODE);

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= S_IDLE;
      lock_cnt  <= '0;
      loss_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        lock_cnt <= '0;
        loss_cnt <= '0;
        tmo_cnt  <= '0;
      end else begin
        case (state)
          S_ROOT, S_EDGE, S_ALL, S_MODE: begin
            tmo_cnt  <= tmo_cnt + 1'b1;
            lock_cnt <= !all_ok ? '0 : (qual ? lock_cnt : lock_cnt + 1'b1);
          end
          S_RAMP:   tmo_cnt  <= step ? '0 : tmo_cnt + 1'b1;
          S_LOCKED: loss_cnt <= any_oor ? loss_cnt + 1'b1 : '0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      kp_r        <= '0;
      ki_r        <= '0;
      kp_fin_r    <= '0;
      ki_fin_r    <= '0;
      uni_sel     <= 1'b1;
      bi_active   <= 1'b0;
      lock_lost_r <= 1'b0;
      locked_r    <= 1'b0;
      fault_r     <= 1'b0;
      enable_r    <= '0;
      weights_r   <= UNI_W;
    end else begin
      if (state_nxt == S_IDLE) begin
        kp_r <= '0;
        ki_r <= '0;
      end else if ((state == S_IDLE && state_nxt == S_ROOT) ||
                   (state == S_LOCKED && state_nxt == S_ALL)) begin
        kp_r <= bus.kp_acq_i;
        ki_r <= bus.ki_acq_i;
      end else if (step) begin
        kp_r <= toward(kp_r, kp_fin_r);
        ki_r <= toward(ki_r, ki_fin_r);
      end
      if (state_nxt == S_RAMP && state != S_RAMP) begin
        kp_fin_r <= bus.kp_fin_i;
        ki_fin_r <= bus.ki_fin_i;
      end
      if (state == S_IDLE && state_nxt == S_ROOT) uni_sel <= bus.uni_dir_i;
      if (bus.clear_i)                                     lock_lost_r <= 1'b0;
      else if (state == S_LOCKED && state_nxt == S_ALL)    lock_lost_r <= 1'b1;
      bi_active <= bi_active_nxt;
      weights_r <= (bi_active_nxt && !uni_sel) ? BI_W : UNI_W;
      enable_r  <= en_of(state_nxt);
      locked_r  <= (state_nxt == S_LOCKED);
      fault_r   <= (state_nxt == S_FAULT);
    end
  end

  assign bus.state_o      = state;
  assign bus.enable_o     = enable_r;
  assign bus.weights_11_o = weights_r[0];
  assign bus.weights_12_o = weights_r[1];
  assign bus.weights_21_o = weights_r[2];
  assign bus.weights_22_o = weights_r[3];
  assign bus.kp_o         = kp_r;
  assign bus.ki_o         = ki_r;
  assign bus.locked_o     = locked_r;
  assign bus.fault_o      = fault_r;
  assign bus.lock_lost_o  = lock_lost_r;
endmodule

// File: tb/tb_adpll_network_sequencer.sv
// Directed bench for adpll_network_sequencer: table-driven nominal bring-up plus
// hand-written glitch, timeout, lock-loss, priority and async-reset sequences.
module tb_adpll_network_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  adpll_network_sequencer_if #(.PDET_WIDTH(8)) bus ();

  adpll_network_sequencer #(
    .PDET_WIDTH(8), .LOCK_THRESH(4), .LOCK_CYCLES(8), .LOSS_CYCLES(4),
    .TIMEOUT_CYCLES(64), .GAIN_STEP_CYCLES(4), .CNT_WIDTH(21)
  ) dut (
    .fpga_clk_i (clk),
    .reset_i    (rst),
    .bus        (bus)
  );

  typedef struct {
    logic        start;
    int          hold;
    logic [2:0]  st;
    logic [3:0]  en;
    logic [3:0]  kp;
    logic [3:0]  ki;
    logic [15:0] w11;
    logic [15:0] w21;
    logic        lk;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic start, int hold, logic [2:0] st, logic [3:0] en,
                              logic [3:0] kp, logic [3:0] ki, logic [15:0] w11,
                              logic [15:0] w21, logic lk);
    vec_t v;
    v.start = start; v.hold = hold; v.st = st; v.en = en; v.kp = kp; v.ki = ki;
    v.w11 = w11; v.w21 = w21; v.lk = lk;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    int k;
    k = 0;
    while (bus.state_o !== s && k < budget) begin
      tick(1);
      k++;
    end
    check(nm, 32'(bus.state_o), 32'(s));
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, ".st"},   32'(bus.state_o),      32'd0);
    check({nm, ".en"},   32'(bus.enable_o),     32'd0);
    check({nm, ".kp"},   32'(bus.kp_o),         32'd0);
    check({nm, ".ki"},   32'(bus.ki_o),         32'd0);
    check({nm, ".w11"},  32'(bus.weights_11_o), 32'h4000);
    check({nm, ".w12"},  32'(bus.weights_12_o), 32'h4000);
    check({nm, ".w21"},  32'(bus.weights_21_o), 32'h0400);
    check({nm, ".w22"},  32'(bus.weights_22_o), 32'h2200);
    check({nm, ".flags"}, 32'({bus.locked_o, bus.fault_o, bus.lock_lost_o}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_i = 0; bus.clear_i = 0; bus.uni_dir_i = 0;
    bus.kp_acq_i = 4'd8; bus.ki_acq_i = 4'd8; bus.kp_fin_i = 4'd2; bus.ki_fin_i = 4'd5;
    bus.err_11_i = 0; bus.err_12_i = 0; bus.err_21_i = 0; bus.err_22_i = 0;

    // Nominal bring-up: every qualifying stage lasts 9 cycles, then the ramp.
    tbl.push_back(mk(1, 1, 3'd1, 4'h1, 8, 8, 16'h4000, 16'h0400, 0));
    tbl.push_back(mk(0, 8, 3'd1, 4'h1, 8, 8, 16'h4000, 16'h0400, 0));
    tbl.push_back(mk(0, 1, 3'd2, 4'h7, 8, 8, 16'h4000, 16'h0400, 0));
    tbl.push_back(mk(0, 8, 3'd2, 4'h7, 8, 8, 16'h4000, 16'h0400, 0));
    tbl.push_back(mk(0, 1, 3'd3, 4'hF, 8, 8, 16'h4000, 16'h0400, 0));
    tbl.push_back(mk(0, 8, 3'd3, 4'hF, 8, 8, 16'h4000, 16'h0400, 0));
    tbl.push_back(mk(0, 1, 3'd4, 4'hF, 8, 8, 16'h2011, 16'h0220, 0));
    tbl.push_back(mk(0, 8, 3'd4, 4'hF, 8, 8, 16'h2011, 16'h0220, 0));
    tbl.push_back(mk(0, 1, 3'd5, 4'hF, 8, 8, 16'h2011, 16'h0220, 0));
    tbl.push_back(mk(0, 3, 3'd5, 4'hF, 8, 8, 16'h2011, 16'h0220, 0));
    tbl.push_back(mk(0, 1, 3'd5, 4'hF, 7, 7, 16'h2011, 16'h0220, 0));
    tbl.push_back(mk(0, 4, 3'd5, 4'hF, 6, 6, 16'h2011, 16'h0220, 0));
    tbl.push_back(mk(0, 4, 3'd5, 4'hF, 5, 5, 16'h2011, 16'h0220, 0));
    tbl.push_back(mk(0, 4, 3'd5, 4'hF, 4, 5, 16'h2011, 16'h0220, 0));
    tbl.push_back(mk(0, 4, 3'd5, 4'hF, 3, 5, 16'h2011, 16'h0220, 0));
    tbl.push_back(mk(0, 4, 3'd5, 4'hF, 2, 5, 16'h2011, 16'h0220, 0));
    tbl.push_back(mk(0, 1, 3'd6, 4'hF, 2, 5, 16'h2011, 16'h0220, 1));

    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      bus.start_i = tbl[i].start;
      tick(tbl[i].hold);
      check($sformatf("nom%0d.st", i),  32'(bus.state_o),      32'(tbl[i].st));
      check($sformatf("nom%0d.en", i),  32'(bus.enable_o),     32'(tbl[i].en));
      check($sformatf("nom%0d.kp", i),  32'(bus.kp_o),         32'(tbl[i].kp));
      check($sformatf("nom%0d.ki", i),  32'(bus.ki_o),         32'(tbl[i].ki));
      check($sformatf("nom%0d.w11", i), 32'(bus.weights_11_o), 32'(tbl[i].w11));
      check($sformatf("nom%0d.w21", i), 32'(bus.weights_21_o), 32'(tbl[i].w21));
      check($sformatf("nom%0d.lk", i),  32'(bus.locked_o),     32'(tbl[i].lk));
    end

    // Lock loss: a 3-cycle burst is tolerated, a 4-cycle burst falls back to ALL.
    bus.err_22_i = 8'd20; tick(3);
    bus.err_22_i = 8'd0;  tick(1);
    check("burst3.st", 32'(bus.state_o), 32'd6);
    check("burst3.lost", 32'(bus.lock_lost_o), 32'd0);
    bus.err_22_i = 8'd20; tick(3);
    check("burst4_pre.st", 32'(bus.state_o), 32'd6);
    tick(1);
    bus.err_22_i = 8'd0;
    check("loss.st", 32'(bus.state_o), 32'd3);
    check("loss.lost", 32'(bus.lock_lost_o), 32'd1);
    check("loss.gains", 32'({bus.kp_o, bus.ki_o}), 32'h88);
    check("loss.lk", 32'(bus.locked_o), 32'd0);
    check("loss.w11", 32'(bus.weights_11_o), 32'h2011);
    check("loss.en", 32'(bus.enable_o), 32'hF);

    bus.clear_i = 1; tick(1); bus.clear_i = 0;
    check_reset_vals("clear");

    // start and clear together in IDLE: clear wins.
    bus.start_i = 1; bus.clear_i = 1; tick(1);
    bus.start_i = 0; bus.clear_i = 0;
    check("prio.st", 32'(bus.state_o), 32'd0);
    check("prio.kp", 32'(bus.kp_o), 32'd0);

    // Glitch restart in ROOT (|e|=4 is in-lock, 5 is not), then EDGE timeout on -128.
    bus.uni_dir_i = 1; bus.err_11_i = 8'hFC; bus.err_12_i = 8'h80;
    bus.start_i = 1; tick(1); bus.start_i = 0;
    check("glitch.entry", 32'(bus.state_o), 32'd1);
    tick(6);
    bus.err_11_i = 8'd5; tick(1);
    bus.err_11_i = 8'd0; tick(8);
    check("glitch.hold", 32'(bus.state_o), 32'd1);
    tick(1);
    check("glitch.adv", 32'(bus.state_o), 32'd2);
    check("glitch.en", 32'(bus.enable_o), 32'h7);
    tick(63);
    check("tmo.pre", 32'(bus.state_o), 32'd2);
    tick(1);
    check("tmo.st", 32'(bus.state_o), 32'd7);
    check("tmo.fault", 32'(bus.fault_o), 32'd1);
    check("tmo.en", 32'(bus.enable_o), 32'h0);
    tick(3);
    check("tmo.hold", 32'(bus.state_o), 32'd7);
    bus.err_12_i = 8'd0;
    bus.clear_i = 1; tick(1); bus.clear_i = 0;
    check("tmo.clear", 32'(bus.state_o), 32'd0);
    check("tmo.fault_clr", 32'(bus.fault_o), 32'd0);

    // Uni-dir bring-up, async reset pulse mid-ramp.
    bus.kp_acq_i = 4'd3; bus.ki_acq_i = 4'd3; bus.kp_fin_i = 4'd9; bus.ki_fin_i = 4'd0;
    bus.start_i = 1; tick(1); bus.start_i = 0;
    wait_state(3'd5, 60, "uni.ramp");
    check("uni.w11", 32'(bus.weights_11_o), 32'h4000);
    check("uni.w21", 32'(bus.weights_21_o), 32'h0400);
    tick(2);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check_reset_vals("async");
    @(negedge clk);
    rst = 1'b0;

    // Gains already at final values: RAMP lasts a single cycle.
    bus.uni_dir_i = 0;
    bus.kp_acq_i = 4'd6; bus.ki_acq_i = 4'd6; bus.kp_fin_i = 4'd6; bus.ki_fin_i = 4'd6;
    bus.start_i = 1; tick(1); bus.start_i = 0;
    wait_state(3'd5, 60, "eq.ramp");
    tick(1);
    check("eq.st", 32'(bus.state_o), 32'd6);
    check("eq.lk", 32'(bus.locked_o), 32'd1);
    check("eq.w11", 32'(bus.weights_11_o), 32'h2011);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
